sdram_wb_arbiter: RTL and testbench
===================================

# sdram_wb_arbiter

Two-master Wishbone arbiter that sits directly upstream of the SDRAM controller in the user project. It accepts single-beat classic Wishbone transactions from the CPU port and the DMA port, picks one with round-robin and a bounded DMA/CPU lock, and issues it to the controller's request interface as a registered one-cycle `ctrl_in_valid` pulse. It then returns the acknowledge, with read data for reads, to the granted master only.

## Interface
Parameters:
- MAX_LOCK, 8: transactions a master may win back-to-back while its cyc stays high and the other master is requesting.
- CNT_W, 4: width of the lock counter; must satisfy 2^CNT_W > MAX_LOCK.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- cpu_cyc_i, cpu_stb_i, cpu_we_i  in  1 each  CPU Wishbone cycle, strobe, write-enable.
- cpu_sel_i  in  4  CPU byte select.
- cpu_adr_i  in  32  CPU address; only [22:0] is used.
- cpu_dat_i  in  32  CPU write data.
- cpu_ack_o  out  1  CPU acknowledge.
- cpu_dat_o  out  32  CPU read data.
- dma_cyc_i, dma_stb_i, dma_we_i, dma_sel_i, dma_adr_i, dma_dat_i, dma_ack_o, dma_dat_o: same widths and meanings, for the DMA port.
- ctrl_addr  out  23  controller word address.
- ctrl_rw  out  1  1 means write.
- ctrl_data_in  out  32  write data to the controller.
- ctrl_mask  out  4  byte mask; equals sel on writes, 0 on reads.
- ctrl_in_valid  out  1  request pulse, one cycle long.
- ctrl_busy  in  1  controller cannot accept a request.
- ctrl_data_out  in  32  controller read data.
- ctrl_out_valid  in  1  read data valid, one cycle.
- grant_dma  out  1  1 while the current or last grant is DMA.

## Operation
- req_x = x_cyc_i & x_stb_i.
- FSM states: IDLE, ISSUE, WAIT_RD, ACK.
- IDLE, leave when req_cpu | req_dma:
  - Only one master requests: grant it.
  - Both request: grant the master that is not last_grant, unless lock applies.
  - Lock applies when the last_grant master still has cyc high and lock_cnt < MAX_LOCK; it then keeps the grant.
  - Go to ISSUE on the same edge.
  - Latch adr[22:0], we, dat, and sel & {4{we}} from the granted master into the ctrl_* registers.
- ISSUE:
  - Hold while ctrl_busy = 1; ctrl_in_valid stays 0.
  - Otherwise assert ctrl_in_valid for exactly one cycle.
  - Next state is ACK for a write and WAIT_RD for a read.
- WAIT_RD: on ctrl_out_valid, latch ctrl_data_out into rd_data and go to ACK.
- ACK:
  - Assert the granted master's ack_o for one cycle.
  - The granted master's dat_o = rd_data; the non-granted master's dat_o holds its previous value.
  - Next state is IDLE.
- Lock counter:
  - Increments on each ACK when the grant equals the previous grant.
  - Resets to 1 when the grant changes.
  - Resets to 0 when the granted master drops cyc while in IDLE.
  - Saturates at MAX_LOCK.
- ctrl_out_valid outside WAIT_RD is ignored.
- A request whose master drops stb before ACK is still completed on the controller side. The ack is still driven, and the master ignores it.
- Only one transaction is outstanding at any time; there is no pipelining.

## Timing
- Reset values:
  - State IDLE, last_grant = CPU, lock_cnt = 0.
  - All ack_o = 0, ctrl_in_valid = 0, grant_dma = 0.
  - ctrl_addr, ctrl_rw, ctrl_data_in, ctrl_mask, rd_data and both dat_o = 0.
- Reset mid-transaction aborts to IDLE on the next edge with no ack. A controller out_valid that arrives afterwards is ignored.
- Write latency: stb seen in IDLE at cycle 0, ctrl_in_valid at cycle 1 (if not busy), ack at cycle 2.
- Read latency: ack comes 1 cycle after ctrl_out_valid.
- No combinational path from any input to ack_o or ctrl_in_valid; all outputs are registered.
- The cycle after ack is IDLE. The master must have deasserted or renewed stb by then (classic Wishbone), so no duplicate issue occurs.

## Test plan
- CPU write 0x3800_0010 with data 0xDEADBEEF, sel 0xF, controller idle -> ctrl_in_valid at cycle 1 with ctrl_addr 0x000010, ctrl_mask 0xF; cpu_ack_o at cycle 2; dma_ack_o stays 0.
- CPU read with ctrl_out_valid 5 cycles after the issue pulse, data 0x1234_5678 -> ctrl_mask 0; cpu_ack_o one cycle after out_valid; cpu_dat_o = 0x12345678.
- CPU and DMA both request from reset (last_grant CPU) -> DMA served first, then CPU; grant_dma goes 1 then 0.
- DMA holds cyc through 12 writes while CPU requests continuously, MAX_LOCK = 8 -> 8 DMA acks, then 1 CPU ack, then DMA resumes.
- ctrl_busy held high for 4 cycles in ISSUE -> no ctrl_in_valid during those cycles; one pulse on the first cycle busy is low.
- rst asserted in WAIT_RD, then out_valid arrives -> no ack on either port; the FSM is in IDLE and outputs are at reset values.

Source files
------------

// File: rtl/sdram_wb_arbiter.sv
// sdram_wb_arbiter
// ----------------
// Two-master Wishbone arbiter placed directly upstream of the SDRAM controller.
// It accepts single-beat classic Wishbone transactions from a CPU port and a
// DMA port. It chooses one requester with round-robin, plus a bounded lock
// for a master that keeps cyc high. The chosen transaction goes to the
// controller as a registered one-cycle request pulse. The acknowledge, with
// read data for reads, goes back to the granted master only.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   cpu_*_i / cpu_*_o   CPU Wishbone slave port (cyc, stb, we, sel, adr, dat, ack)
//   dma_*_i / dma_*_o   DMA Wishbone slave port (same set)
//   ctrl_addr           controller word address (adr[22:0] of the granted master)
//   ctrl_rw             1 = write
//   ctrl_data_in        write data to the controller
//   ctrl_mask           byte mask: sel on writes, 0 on reads
//   ctrl_in_valid       one-cycle request pulse
//   ctrl_busy           controller cannot take a request
//   ctrl_data_out       controller read data
//   ctrl_out_valid      read data valid (one cycle)
//   grant_dma           1 while the current or last grant is DMA
//   dbg_state_o         FSM state: 0 IDLE, 1 ISSUE, 2 WAIT_RD, 3 ACK
//
// Handshake with the controller: ctrl_in_valid is a registered one-cycle
// pulse. It is raised only when ctrl_busy was low at the preceding clock
// edge. The controller accepts every pulse it sees. There is at most one
// transaction outstanding, and no new request is issued until the
// requesting master has been acknowledged.

module sdram_wb_arbiter #(
    parameter int MAX_LOCK = 8,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_cyc_i,
    input  logic        cpu_stb_i,
    input  logic        cpu_we_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic [31:0] cpu_adr_i,
    input  logic [31:0] cpu_dat_i,
    output logic        cpu_ack_o,
    output logic [31:0] cpu_dat_o,
    input  logic        dma_cyc_i,
    input  logic        dma_stb_i,
    input  logic        dma_we_i,
    input  logic [3:0]  dma_sel_i,
    input  logic [31:0] dma_adr_i,
    input  logic [31:0] dma_dat_i,
    output logic        dma_ack_o,
    output logic [31:0] dma_dat_o,
    output logic [22:0] ctrl_addr,
    output logic        ctrl_rw,
    output logic [31:0] ctrl_data_in,
    output logic [3:0]  ctrl_mask,
    output logic        ctrl_in_valid,
    input  logic        ctrl_busy,
    input  logic [31:0] ctrl_data_out,
    input  logic        ctrl_out_valid,
    output logic        grant_dma,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT_RD = 2'd2,
        S_ACK     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LP_MAX_LOCK = CNT_W'(MAX_LOCK);

    state_t            r_state;
    state_t            w_next_state;

    // Grant encoding: 0 = CPU, 1 = DMA.
    logic              r_grant;
    logic              r_last_grant;
    logic [CNT_W-1:0]  r_lock_cnt;

    logic [22:0]       r_ctrl_addr;
    logic              r_ctrl_rw;
    logic [31:0]       r_ctrl_data_in;
    logic [3:0]        r_ctrl_mask;
    logic              r_ctrl_in_valid;
    logic [31:0]       r_rd_data;
    logic              r_cpu_ack;
    logic              r_dma_ack;
    logic [31:0]       r_cpu_dat;
    logic [31:0]       r_dma_dat;

    logic              w_req_cpu;
    logic              w_req_dma;
    logic              w_last_cyc;
    logic              w_lock;
    logic              w_grant_sel;
    logic              w_start;
    logic              w_valid_nxt;
    logic              w_enter_ack;
    logic              w_rd_capture;
    logic [31:0]       w_ack_data;
    logic [22:0]       w_sel_adr;
    logic              w_sel_we;
    logic [31:0]       w_sel_dat;
    logic [3:0]        w_sel_sel;
    logic              w_unused;

    // Upper address bits are outside the SDRAM word space.
    assign w_unused = ^{cpu_adr_i[31:23], dma_adr_i[31:23]};

    assign w_req_cpu  = cpu_cyc_i & cpu_stb_i;
    assign w_req_dma  = dma_cyc_i & dma_stb_i;
    assign w_last_cyc = r_last_grant ? dma_cyc_i : cpu_cyc_i;

    // The last winner keeps the bus only while it is in an active run. A zero
    // count means it has no run: either the bench is fresh out of reset, or
    // the master dropped cyc. In that case it has no claim, and plain
    // round-robin picks the other master.
    assign w_lock = w_last_cyc && (r_lock_cnt != '0) && (r_lock_cnt < LP_MAX_LOCK);

    always_comb begin
        w_grant_sel = w_req_dma;
        if (w_req_cpu && w_req_dma) begin
            w_grant_sel = w_lock ? r_last_grant : ~r_last_grant;
        end
    end

    always_comb begin
        w_sel_adr = w_grant_sel ? dma_adr_i[22:0] : cpu_adr_i[22:0];
        w_sel_we  = w_grant_sel ? dma_we_i        : cpu_we_i;
        w_sel_dat = w_grant_sel ? dma_dat_i       : cpu_dat_i;
        w_sel_sel = w_grant_sel ? dma_sel_i       : cpu_sel_i;
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req_cpu || w_req_dma) w_next_state = S_ISSUE;
            end
            S_ISSUE: begin
                // Leave only once the request pulse is on the wire this cycle.
                if (r_ctrl_in_valid) w_next_state = r_ctrl_rw ? S_ACK : S_WAIT_RD;
            end
            S_WAIT_RD: begin
                if (ctrl_out_valid) w_next_state = S_ACK;
            end
            S_ACK: begin
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // ---------------- FSM: output decode ----------------
    always_comb begin
        w_start      = (r_state == S_IDLE) && (w_req_cpu || w_req_dma);
        // The pulse is registered, so it uses the busy value sampled on the
        // edge that launches it. It is raised at most once per ISSUE visit.
        w_valid_nxt  = !ctrl_busy &&
                       (w_start || ((r_state == S_ISSUE) && !r_ctrl_in_valid));
        w_enter_ack  = (w_next_state == S_ACK) && (r_state != S_ACK);
        w_rd_capture = (r_state == S_WAIT_RD) && ctrl_out_valid;
        w_ack_data   = w_rd_capture ? ctrl_data_out : r_rd_data;
    end

    // ---------------- datapath / registered outputs ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant         <= 1'b0;
            r_last_grant    <= 1'b0;
            r_lock_cnt      <= '0;
            r_ctrl_addr     <= '0;
            r_ctrl_rw       <= 1'b0;
            r_ctrl_data_in  <= '0;
            r_ctrl_mask     <= '0;
            r_ctrl_in_valid <= 1'b0;
            r_rd_data       <= '0;
            r_cpu_ack       <= 1'b0;
            r_dma_ack       <= 1'b0;
            r_cpu_dat       <= '0;
            r_dma_dat       <= '0;
        end else begin
            r_ctrl_in_valid <= w_valid_nxt;
            r_cpu_ack       <= w_enter_ack & ~r_grant;
            r_dma_ack       <= w_enter_ack &  r_grant;

            if (w_start) begin
                r_grant        <= w_grant_sel;
                r_ctrl_addr    <= w_sel_adr;
                r_ctrl_rw      <= w_sel_we;
                r_ctrl_data_in <= w_sel_dat;
                r_ctrl_mask    <= w_sel_sel & {4{w_sel_we}};
            end

            if (w_rd_capture) r_rd_data <= ctrl_data_out;

            // Only the granted master's data output changes. The other one
            // holds whatever it last returned.
            if (w_enter_ack) begin
                if (r_grant) r_dma_dat <= w_ack_data;
                else         r_cpu_dat <= w_ack_data;
            end

            if (r_state == S_ACK) begin
                r_last_grant <= r_grant;
                if (r_grant == r_last_grant) begin
                    if (r_lock_cnt < LP_MAX_LOCK) r_lock_cnt <= r_lock_cnt + CNT_W'(1);
                end else begin
                    r_lock_cnt <= CNT_W'(1);
                end
            end else if ((r_state == S_IDLE) && !(r_grant ? dma_cyc_i : cpu_cyc_i)) begin
                r_lock_cnt <= '0;
            end
        end
    end

    assign cpu_ack_o     = r_cpu_ack;
    assign dma_ack_o     = r_dma_ack;
    assign cpu_dat_o     = r_cpu_dat;
    assign dma_dat_o     = r_dma_dat;
    assign ctrl_addr     = r_ctrl_addr;
    assign ctrl_rw       = r_ctrl_rw;
    assign ctrl_data_in  = r_ctrl_data_in;
    assign ctrl_mask     = r_ctrl_mask;
    assign ctrl_in_valid = r_ctrl_in_valid;
    assign grant_dma     = r_grant;
    assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// Directed testbench for sdram_wb_arbiter. Inputs are driven and outputs are
// sampled on the falling clock edge. Expected values are hand-derived
// constants, plus an expected-grant queue for the lock test.

module tb_sdram_wb_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cpu_cyc_i = 0, cpu_stb_i = 0, cpu_we_i = 0;
  logic [3:0]  cpu_sel_i = 0;
  logic [31:0] cpu_adr_i = 0, cpu_dat_i = 0;
  logic        cpu_ack_o;
  logic [31:0] cpu_dat_o;
  logic        dma_cyc_i = 0, dma_stb_i = 0, dma_we_i = 0;
  logic [3:0]  dma_sel_i = 0;
  logic [31:0] dma_adr_i = 0, dma_dat_i = 0;
  logic        dma_ack_o;
  logic [31:0] dma_dat_o;
  logic [22:0] ctrl_addr;
  logic        ctrl_rw;
  logic [31:0] ctrl_data_in;
  logic [3:0]  ctrl_mask;
  logic        ctrl_in_valid;
  logic        ctrl_busy = 0;
  logic [31:0] ctrl_data_out = 0;
  logic        ctrl_out_valid = 0;
  logic        grant_dma;
  logic [1:0]  dbg_state_o;

  sdram_wb_arbiter #(.MAX_LOCK(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_cyc_i(cpu_cyc_i), .cpu_stb_i(cpu_stb_i), .cpu_we_i(cpu_we_i),
    .cpu_sel_i(cpu_sel_i), .cpu_adr_i(cpu_adr_i), .cpu_dat_i(cpu_dat_i),
    .cpu_ack_o(cpu_ack_o), .cpu_dat_o(cpu_dat_o),
    .dma_cyc_i(dma_cyc_i), .dma_stb_i(dma_stb_i), .dma_we_i(dma_we_i),
    .dma_sel_i(dma_sel_i), .dma_adr_i(dma_adr_i), .dma_dat_i(dma_dat_i),
    .dma_ack_o(dma_ack_o), .dma_dat_o(dma_dat_o),
    .ctrl_addr(ctrl_addr), .ctrl_rw(ctrl_rw), .ctrl_data_in(ctrl_data_in),
    .ctrl_mask(ctrl_mask), .ctrl_in_valid(ctrl_in_valid), .ctrl_busy(ctrl_busy),
    .ctrl_data_out(ctrl_data_out), .ctrl_out_valid(ctrl_out_valid),
    .grant_dma(grant_dma), .dbg_state_o(dbg_state_o)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_bad   = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic cpu_drive(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel);
    cpu_cyc_i = 1; cpu_stb_i = 1; cpu_we_i = we;
    cpu_adr_i = adr; cpu_dat_i = dat; cpu_sel_i = sel;
  endtask

  task automatic cpu_idle();
    cpu_cyc_i = 0; cpu_stb_i = 0; cpu_we_i = 0;
  endtask

  task automatic dma_drive(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel);
    dma_cyc_i = 1; dma_stb_i = 1; dma_we_i = we;
    dma_adr_i = adr; dma_dat_i = dat; dma_sel_i = sel;
  endtask

  task automatic dma_idle();
    dma_cyc_i = 0; dma_stb_i = 0; dma_we_i = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"},  dbg_state_o,   0);
    check({tag, "_cack"},   cpu_ack_o,     0);
    check({tag, "_dack"},   dma_ack_o,     0);
    check({tag, "_valid"},  ctrl_in_valid, 0);
    check({tag, "_gdma"},   grant_dma,     0);
    check({tag, "_addr"},   ctrl_addr,     0);
    check({tag, "_rw"},     ctrl_rw,       0);
    check({tag, "_din"},    ctrl_data_in,  0);
    check({tag, "_mask"},   ctrl_mask,     0);
    check({tag, "_cdat"},   cpu_dat_o,     0);
    check({tag, "_ddat"},   dma_dat_o,     0);
  endtask

  // ---------------- stimulus ----------------
  int dma_n;
  int cpu_n;
  logic [0:0] got_g;
  logic [0:0] exp_g;

  initial begin
    // Reset values
    tick();
    tick();
    check_reset_outputs("rst");
    rst = 1'b0;

    // T1: CPU write, controller idle
    cpu_drive(1'b1, 32'h3800_0010, 32'hDEAD_BEEF, 4'hF);
    tick();                                   // cycle 1
    check("t1_valid", ctrl_in_valid, 1);
    check("t1_addr",  ctrl_addr, 23'h000010);
    check("t1_mask",  ctrl_mask, 4'hF);
    check("t1_rw",    ctrl_rw, 1);
    check("t1_din",   ctrl_data_in, 32'hDEAD_BEEF);
    check("t1_ack1",  cpu_ack_o, 0);
    tick();                                   // cycle 2
    check("t1_valid2", ctrl_in_valid, 0);
    check("t1_ack",    cpu_ack_o, 1);
    check("t1_dack",   dma_ack_o, 0);
    check("t1_state",  dbg_state_o, 3);
    cpu_idle();
    tick();
    check("t1_ack_off", cpu_ack_o, 0);
    check("t1_idle",    dbg_state_o, 0);

    // T2: CPU read, data 5 cycles after the issue pulse
    cpu_drive(1'b0, 32'h0000_0124, 32'h5555_AAAA, 4'hF);
    tick();                                   // cycle 1: issue pulse
    check("t2_valid", ctrl_in_valid, 1);
    check("t2_mask",  ctrl_mask, 0);
    check("t2_rw",    ctrl_rw, 0);
    check("t2_addr",  ctrl_addr, 23'h000124);
    for (int i = 2; i <= 5; i++) begin
      tick();
      check("t2_wait_ack", cpu_ack_o, 0);
      check("t2_wait_valid", ctrl_in_valid, 0);
    end
    tick();                                   // cycle 6: out_valid
    check("t2_state_wr", dbg_state_o, 2);
    ctrl_out_valid = 1; ctrl_data_out = 32'h1234_5678;
    tick();                                   // cycle 7: ack
    ctrl_out_valid = 0; ctrl_data_out = 0;
    check("t2_ack",  cpu_ack_o, 1);
    check("t2_dat",  cpu_dat_o, 32'h1234_5678);
    check("t2_dack", dma_ack_o, 0);
    check("t2_ddat", dma_dat_o, 0);
    cpu_idle();
    tick();
    check("t2_ack_off", cpu_ack_o, 0);
    check("t2_dat_hold", cpu_dat_o, 32'h1234_5678);
    // Stray out_valid while IDLE is ignored
    ctrl_out_valid = 1; ctrl_data_out = 32'hBAD0_BAD0;
    tick();
    ctrl_out_valid = 0; ctrl_data_out = 0;
    tick();
    check("t2_stray_cack", cpu_ack_o, 0);
    check("t2_stray_dack", dma_ack_o, 0);
    check("t2_stray_state", dbg_state_o, 0);
    check("t2_stray_dat", cpu_dat_o, 32'h1234_5678);

    // T6: reset while in WAIT_RD, late out_valid ignored
    cpu_drive(1'b0, 32'h0000_0777, 32'h1111_2222, 4'hA);
    tick();                                   // cycle 1: issue
    check("t6_valid", ctrl_in_valid, 1);
    check("t6_din",   ctrl_data_in, 32'h1111_2222);
    tick();                                   // cycle 2
    check("t6_state", dbg_state_o, 2);
    tick();                                   // cycle 3
    rst = 1'b1;
    tick();                                   // cycle 4: reset applied
    check_reset_outputs("t6_rst");
    cpu_idle();
    rst = 1'b0;
    ctrl_out_valid = 1; ctrl_data_out = 32'hCAFE_F00D;
    tick();
    ctrl_out_valid = 0; ctrl_data_out = 0;
    check_reset_outputs("t6_post");
    tick();
    check_reset_outputs("t6_post2");

    // T3: both request from reset -> DMA first, then CPU
    do_reset();
    cpu_drive(1'b1, 32'h0000_0100, 32'hC0C0_C0C0, 4'hF);
    dma_drive(1'b1, 32'h0000_0200, 32'hD0D0_D0D0, 4'h3);
    tick();                                   // cycle 1
    check("t3_gdma1",  grant_dma, 1);
    check("t3_valid1", ctrl_in_valid, 1);
    check("t3_addr1",  ctrl_addr, 23'h000200);
    check("t3_mask1",  ctrl_mask, 4'h3);
    tick();                                   // cycle 2
    check("t3_dack1", dma_ack_o, 1);
    check("t3_cack1", cpu_ack_o, 0);
    dma_idle();
    tick();                                   // cycle 3: IDLE
    check("t3_idle",  dbg_state_o, 0);
    check("t3_gdma_hold", grant_dma, 1);
    tick();                                   // cycle 4
    check("t3_gdma2",  grant_dma, 0);
    check("t3_valid2", ctrl_in_valid, 1);
    check("t3_addr2",  ctrl_addr, 23'h000100);
    tick();                                   // cycle 5
    check("t3_cack2", cpu_ack_o, 1);
    check("t3_dack2", dma_ack_o, 0);
    cpu_idle();
    tick();

    // T4: DMA holds cyc through 12 writes, CPU requesting -> 8 DMA, 1 CPU, 4 DMA
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 4; i++) exp_q.push_back(1'b1);
    dma_n = 0;
    cpu_n = 0;
    dma_drive(1'b1, 32'h0000_0300, 32'hD000_0000, 4'hF);
    cpu_drive(1'b1, 32'h0000_0400, 32'hC000_0000, 4'h3);
    for (int k = 0; k < 400 && (dma_n < 12 || cpu_n < 1); k++) begin
      tick();
      check("t4_dual_ack", cpu_ack_o & dma_ack_o, 0);
      if (ctrl_in_valid && grant_dma) check("t4_addr", ctrl_addr, 23'h300 + 23'(dma_n));
      if (cpu_ack_o || dma_ack_o) begin
        got_g = dma_ack_o;
        exp_g = (exp_q.size() > 0) ? exp_q.pop_front() : ~got_g;
        check("t4_order", got_g, exp_g);
        if (dma_ack_o) begin
          dma_n++;
          if (dma_n < 12) dma_drive(1'b1, 32'h0000_0300 + dma_n, 32'hD000_0000 + dma_n, 4'hF);
          else dma_idle();
        end
        if (cpu_ack_o) begin
          cpu_n++;
          cpu_idle();
        end
      end
    end
    check("t4_dma_n", dma_n, 12);
    check("t4_cpu_n", cpu_n, 1);
    check("t4_q_left", exp_q.size(), 0);
    cpu_idle();
    dma_idle();
    tick();

    // T5: busy held in ISSUE, single pulse once busy drops
    do_reset();
    ctrl_busy = 1;
    cpu_drive(1'b1, 32'h0000_0055, 32'h0BAD_F00D, 4'h5);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("t5_busy_valid", ctrl_in_valid, 0);
      check("t5_busy_state", dbg_state_o, 1);
      if (i == 4) ctrl_busy = 0;
    end
    tick();                                   // first cycle with busy low
    check("t5_valid", ctrl_in_valid, 1);
    check("t5_addr",  ctrl_addr, 23'h000055);
    check("t5_mask",  ctrl_mask, 4'h5);
    check("t5_ack_early", cpu_ack_o, 0);
    tick();
    check("t5_valid_off", ctrl_in_valid, 0);
    check("t5_ack", cpu_ack_o, 1);
    cpu_idle();
    tick();
    check("t5_valid_none", ctrl_in_valid, 0);
    check("t5_idle", dbg_state_o, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
